// File: rtl/vga_vram_scheduler.sv
// ============================================================================
// Module      : vga_vram_scheduler
// Description : Time-slot scheduler for a single-port synchronous tile RAM
//               behind an 80x60 tile text/graphics display. Display fetches
//               take every 8th active pixel tick; the remaining clocks are
//               shared round-robin between two write requesters.
//
// Ports
//   clk, reset            : clock and asynchronous active-high reset
//   pixel_tick, video_on,
//   pixel_x, pixel_y      : timing from the sync generator
//   req_x, addr_x, data_x : write request, tile address and data (x = a, b)
//   gnt_x                 : one-cycle grant pulse
//   wr_err                : one-cycle pulse for a granted but rejected write
//                           (address outside the 4800-entry tile map)
//   mem_addr, mem_we,
//   mem_wdata, mem_rdata  : tile RAM port (read data one clk after address)
//   tile_code, tile_valid : last fetched tile code and its one-cycle strobe
//
// Build option
//   VRAM_BLANK_ONLY_WR_EN : when defined, write grants are only issued while
//                           video_on is low; requests in active video wait.
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_vram_scheduler (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_tick,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [12:0] addr_a,
    input  logic [12:0] addr_b,
    input  logic [7:0]  data_a,
    input  logic [7:0]  data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        wr_err,
    output logic [12:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  tile_code,
    output logic        tile_valid
);

    localparam logic [12:0] C_TILE_COUNT = 13'd4800;
    localparam logic [12:0] C_TILE_COLS  = 13'd80;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DISP = 2'd1,
        S_WR   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_last_gnt_b;   // 1 when B received the most recent grant
    logic [12:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_mem_we;
    logic        r_gnt_a;
    logic        r_gnt_b;
    logic        r_wr_err;
    logic        r_fetch_d1;     // RAM data for a fetch arrives this cycle
    logic [7:0]  r_tile_code;
    logic        r_tile_valid;

    // ------------------------------------------------------------------
    // Combinational decision
    // ------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [12:0] w_addr_nxt;
    logic [7:0]  w_wdata_nxt;
    logic        w_we_nxt;
    logic        w_gnt_a_nxt;
    logic        w_gnt_b_nxt;
    logic        w_err_nxt;

    logic        w_disp_slot;
    logic [12:0] w_fetch_addr;
    logic        w_any_req;
    logic        w_wr_allow;
    logic        w_pick_b;
    logic [12:0] w_sel_addr;
    logic [7:0]  w_sel_data;
    logic        w_sel_in_range;

    assign w_disp_slot = pixel_tick & video_on & (pixel_x[2:0] == 3'd0);

    // Row and column are widened before the multiply so the product is
    // formed at full address width.
    assign w_fetch_addr = ({6'd0, pixel_y[9:3]} * C_TILE_COLS)
                        + {6'd0, pixel_x[9:3]};

    assign w_any_req = req_a | req_b;

`ifdef VRAM_BLANK_ONLY_WR_EN
    assign w_wr_allow = ~video_on;
`else
    assign w_wr_allow = 1'b1;
`endif

    // Round robin: on a tie, B wins only if A was served last.
    assign w_pick_b       = req_b & (~req_a | ~r_last_gnt_b);
    assign w_sel_addr     = w_pick_b ? addr_b : addr_a;
    assign w_sel_data     = w_pick_b ? data_b : data_a;
    assign w_sel_in_range = (w_sel_addr < C_TILE_COUNT);

    always_comb begin
        w_state_nxt = S_IDLE;
        w_addr_nxt  = r_mem_addr;
        w_wdata_nxt = r_mem_wdata;
        w_we_nxt    = 1'b0;
        w_gnt_a_nxt = 1'b0;
        w_gnt_b_nxt = 1'b0;
        w_err_nxt   = 1'b0;

        if (w_disp_slot) begin
            // Display fetch beats everything, including pending writes.
            w_state_nxt = S_DISP;
            w_addr_nxt  = w_fetch_addr;
        end else if ((r_state != S_WR) && w_any_req && w_wr_allow) begin
            // A write is never decided while a grant is being issued: the
            // requester's req is still the stale one in that cycle.
            w_state_nxt = S_WR;
            w_addr_nxt  = w_sel_addr;
            w_wdata_nxt = w_sel_data;
            w_we_nxt    = w_sel_in_range;
            w_err_nxt   = ~w_sel_in_range;
            w_gnt_a_nxt = ~w_pick_b;
            w_gnt_b_nxt = w_pick_b;
        end
    end

    // ------------------------------------------------------------------
    // State and registered RAM-port / grant outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_gnt_b <= 1'b1;
            r_mem_addr   <= 13'd0;
            r_mem_wdata  <= 8'd0;
            r_mem_we     <= 1'b0;
            r_gnt_a      <= 1'b0;
            r_gnt_b      <= 1'b0;
            r_wr_err     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_addr   <= w_addr_nxt;
            r_mem_wdata  <= w_wdata_nxt;
            r_mem_we     <= w_we_nxt;
            r_gnt_a      <= w_gnt_a_nxt;
            r_gnt_b      <= w_gnt_b_nxt;
            r_wr_err     <= w_err_nxt;
            if (w_gnt_a_nxt | w_gnt_b_nxt) begin
                r_last_gnt_b <= w_gnt_b_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tile fetch return path: address in cycle N, RAM data in N+1,
    // captured at the end of N+1, strobed in N+2.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_d1   <= 1'b0;
            r_tile_code  <= 8'd0;
            r_tile_valid <= 1'b0;
        end else begin
            r_fetch_d1   <= (r_state == S_DISP);
            r_tile_valid <= r_fetch_d1;
            if (r_fetch_d1) begin
                r_tile_code <= mem_rdata;
            end
        end
    end

    assign gnt_a      = r_gnt_a;
    assign gnt_b      = r_gnt_b;
    assign wr_err     = r_wr_err;
    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign tile_code  = r_tile_code;
    assign tile_valid = r_tile_valid;

endmodule

`default_nettype wire

// File: tb/tb_vga_vram_scheduler.sv
// ============================================================================
// Module      : tb_vga_vram_scheduler
// Description : Self-checking bench for vga_vram_scheduler with a behavioural
//               tile RAM, directed scenarios and a randomized run against a
//               cycle-level reference model of the scheduling rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_vram_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        pixel_tick, video_on;
    logic [9:0]  pixel_x, pixel_y;
    logic        req_a, req_b;
    logic [12:0] addr_a, addr_b;
    logic [7:0]  data_a, data_b;
    logic        gnt_a, gnt_b, wr_err, mem_we, tile_valid;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata, tile_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_vram_scheduler u_dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_tick (pixel_tick),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .req_a      (req_a),
        .req_b      (req_b),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .data_a     (data_a),
        .data_b     (data_b),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b),
        .wr_err     (wr_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .tile_code  (tile_code),
        .tile_valid (tile_valid)
    );

    // Synchronous single-port tile RAM, filled with random content once.
    logic [7:0] ram [0:8191];
    logic       ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 8192; i++) ram[i] <= 8'($urandom);
            ram_ready <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    logic [33:0] all_out;
    assign all_out = {gnt_a, gnt_b, wr_err, mem_we, tile_valid,
                      mem_addr, mem_wdata, tile_code};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        pixel_tick = 1'b0; video_on = 1'b0;
        pixel_x = 10'd0;   pixel_y = 10'd0;
        req_a = 1'b0;      req_b = 1'b0;
        addr_a = 13'd0;    addr_b = 13'd0;
        data_a = 8'd0;     data_b = 8'd0;
    endtask

    task automatic settle();
        quiet_inputs();
        repeat (4) tick();
    endtask

    function automatic logic [12:0] rand_addr();
        if ($urandom_range(7, 0) == 0) return 13'($urandom_range(8191, 4800));
        return 13'($urandom_range(4799, 0));
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        quiet_inputs();
        req_a = 1'b1; req_b = 1'b1; video_on = 1'b1; pixel_tick = 1'b1;
        repeat (3) tick();
        checks++;
        if (all_out !== 34'd0) begin
            errors++;
            $display("FAIL reset_hold outputs=%h required=0", all_out);
        end
        quiet_inputs();
        tick();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (all_out !== 34'd0) begin
            errors++;
            $display("FAIL reset_release_quiet outputs=%h required=0", all_out);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_robin();
        logic ea, eb;
        reset = 1'b1;
        tick();
        quiet_inputs();
        req_a = 1'b1; req_b = 1'b1;
        addr_a = 13'($urandom_range(4799, 0)); data_a = 8'($urandom);
        addr_b = 13'($urandom_range(4799, 0)); data_b = 8'($urandom);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            ea = (i % 4 == 1);
            eb = (i % 4 == 3);
            checks++;
            if ({gnt_a, gnt_b, mem_we} !== {ea, eb, ea | eb}) begin
                errors++;
                $display("FAIL rr_grant cycle %0d gnt_a/gnt_b/we=%b%b%b required %b%b%b",
                         i, gnt_a, gnt_b, mem_we, ea, eb, ea | eb);
            end
            if (ea || eb) begin
                checks++;
                if ({mem_addr, mem_wdata} !== (ea ? {addr_a, data_a} : {addr_b, data_b})) begin
                    errors++;
                    $display("FAIL rr_port cycle %0d addr=%0d data=%h", i, mem_addr, mem_wdata);
                end
            end
        end
        settle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_fetch();
        int          xs [3] = '{8, 639, 0};
        int          ys [3] = '{16, 479, 0};
        logic [12:0] ea;
        logic [7:0]  code;
        for (int k = 0; k < 3; k++) begin
            ea = 13'((ys[k] / 8) * 80 + xs[k] / 8);
            code = ram[ea];
            video_on = 1'b1; pixel_tick = 1'b1;
            pixel_x = 10'(xs[k] & ~7); pixel_y = 10'(ys[k]);
            tick();
            pixel_tick = 1'b0;
            checks++;
            if ({mem_addr, mem_we, tile_valid} !== {ea, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL fetch_addr addr=%0d we=%b tv=%b required addr=%0d we=0 tv=0",
                         mem_addr, mem_we, tile_valid, ea);
            end
            tick();
            checks++;
            if (tile_valid !== 1'b0) begin
                errors++;
                $display("FAIL fetch_early tile_valid=%b required 0", tile_valid);
            end
            tick();
            checks++;
            if ({tile_valid, tile_code} !== {1'b1, code}) begin
                errors++;
                $display("FAIL fetch_data tv=%b code=%h required tv=1 code=%h",
                         tile_valid, tile_code, code);
            end
            tick();
            checks++;
            if ({tile_valid, tile_code} !== {1'b0, code}) begin
                errors++;
                $display("FAIL fetch_hold tv=%b code=%h required tv=0 code=%h",
                         tile_valid, tile_code, code);
            end
        end
        settle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_wr_err();
        logic [12:0] adrs [3] = '{13'd4799, 13'd4800, 13'd8191};
        logic        inr;
        for (int k = 0; k < 3; k++) begin
            inr = (adrs[k] < 13'd4800);
            req_a = 1'b1; addr_a = adrs[k]; data_a = 8'($urandom);
            tick();
            checks++;
            if ({gnt_a, wr_err, mem_we} !== {1'b1, !inr, inr}) begin
                errors++;
                $display("FAIL wr_range addr=%0d gnt/err/we=%b%b%b required 1%b%b",
                         adrs[k], gnt_a, wr_err, mem_we, !inr, inr);
            end
            req_a = 1'b0;
            tick();
            checks++;
            if ({gnt_a, wr_err, mem_we} !== 3'b000) begin
                errors++;
                $display("FAIL wr_range_after gnt/err/we=%b%b%b required 000",
                         gnt_a, wr_err, mem_we);
            end
        end
        settle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_preempt();
        video_on = 1'b1; pixel_tick = 1'b1; pixel_x = 10'd16; pixel_y = 10'd0;
        req_b = 1'b1; addr_b = 13'd100; data_b = 8'h5A;
        tick();
        checks++;
        if ({mem_addr, mem_we, gnt_b} !== {13'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL preempt_fetch addr=%0d we=%b gnt_b=%b required addr=2 we=0 gnt_b=0",
                     mem_addr, mem_we, gnt_b);
        end
        pixel_tick = 1'b0; video_on = 1'b0;
        tick();
        checks++;
        if ({gnt_b, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 13'd100, 8'h5A}) begin
            errors++;
            $display("FAIL preempt_grant gnt_b=%b we=%b addr=%0d data=%h required 1 1 100 5a",
                     gnt_b, mem_we, mem_addr, mem_wdata);
        end
        settle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        // Abort during a write grant, request withdrawn.
        req_a = 1'b1; addr_a = 13'd10; data_a = 8'h11;
        tick();
        checks++;
        if (gnt_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_wr_setup gnt_a=%b required 1", gnt_a);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (all_out !== 34'd0) begin
            errors++;
            $display("FAIL mid_wr_async outputs=%h required 0", all_out);
        end
        req_a = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({gnt_a, gnt_b, mem_we} !== 3'b000) begin
                errors++;
                $display("FAIL mid_wr_after cycle %0d gnt/we=%b%b%b required 000",
                         i, gnt_a, gnt_b, mem_we);
            end
        end
        // Abort during a write grant, request still held: served again.
        req_a = 1'b1;
        tick();
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({gnt_a, mem_we} !== 2'b11) begin
            errors++;
            $display("FAIL mid_wr_reserve gnt_a/we=%b%b required 11", gnt_a, mem_we);
        end
        settle();
        // Abort during a fetch: no tile strobe afterwards.
        video_on = 1'b1; pixel_tick = 1'b1; pixel_x = 10'd24; pixel_y = 10'd8;
        tick();
        pixel_tick = 1'b0;
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (tile_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_fetch_after cycle %0d tile_valid=%b required 0", i, tile_valid);
            end
        end
        settle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_blank_gate();
        video_on = 1'b1; pixel_tick = 1'b0; pixel_x = 10'd3; pixel_y = 10'd40;
        req_a = 1'b1; addr_a = 13'd77; data_a = 8'hC3;
`ifdef VRAM_BLANK_ONLY_WR_EN
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (gnt_a !== 1'b0) begin
                errors++;
                $display("FAIL blank_wait cycle %0d gnt_a=%b required 0", i, gnt_a);
            end
        end
        video_on = 1'b0;
        tick();
        checks++;
        if ({gnt_a, mem_we} !== 2'b11) begin
            errors++;
            $display("FAIL blank_grant gnt_a/we=%b%b required 11", gnt_a, mem_we);
        end
`else
        tick();
        checks++;
        if ({gnt_a, mem_we, mem_addr} !== {1'b1, 1'b1, 13'd77}) begin
            errors++;
            $display("FAIL active_grant gnt_a=%b we=%b addr=%0d required 1 1 77",
                     gnt_a, mem_we, mem_addr);
        end
`endif
        settle();
    endtask

    // ------------------------------------------------------------------
    // Randomized run. The model tracks what kind of cycle (idle, fetch,
    // write) the DUT should be presenting and when fetched codes return.
    task automatic test_random();
        int          e_kind;   // 0 idle, 1 fetch, 2 write
        logic        e_ga, e_gb, e_we, e_err;
        logic [12:0] e_addr;
        logic [7:0]  e_wd, e_code, h1_c, h2_c;
        logic        h1_v, h2_v, last_b, seen_a, seen_b, slot, allow, pick_b;

        reset = 1'b1;
        quiet_inputs();
        tick();
        reset = 1'b0;
        e_kind = 0; e_ga = 0; e_gb = 0; e_we = 0; e_err = 0;
        e_addr = 13'd0; e_wd = 8'd0; e_code = 8'd0;
        h1_v = 0; h2_v = 0; h1_c = 8'd0; h2_c = 8'd0;
        last_b = 1'b1; seen_a = 0; seen_b = 0;

        for (int c = 0; c < 3000; c++) begin
            tick();
            checks++;
            if ({gnt_a, gnt_b} !== {e_ga, e_gb}) begin
                errors++;
                $display("FAIL rnd_gnt cycle %0d got %b%b required %b%b", c, gnt_a, gnt_b, e_ga, e_gb);
            end
            checks++;
            if ({mem_we, wr_err} !== {e_we, e_err}) begin
                errors++;
                $display("FAIL rnd_we_err cycle %0d got %b%b required %b%b", c, mem_we, wr_err, e_we, e_err);
            end
            if (e_kind != 0) begin
                checks++;
                if (mem_addr !== e_addr) begin
                    errors++;
                    $display("FAIL rnd_addr cycle %0d got %0d required %0d", c, mem_addr, e_addr);
                end
            end
            if (e_kind == 2) begin
                checks++;
                if (mem_wdata !== e_wd) begin
                    errors++;
                    $display("FAIL rnd_wdata cycle %0d got %h required %h", c, mem_wdata, e_wd);
                end
            end
            if (h2_v) e_code = h2_c;
            checks++;
            if ({tile_valid, tile_code} !== {h2_v, e_code}) begin
                errors++;
                $display("FAIL rnd_tile cycle %0d got %b/%h required %b/%h",
                         c, tile_valid, tile_code, h2_v, e_code);
            end
            h2_v = h1_v; h2_c = h1_c;
            h1_v = (e_kind == 1);
            h1_c = ram[e_addr];

            // Requesters: hold until granted, then drop or renew.
            if (seen_a) begin
                if ($urandom_range(1, 0) == 0) req_a = 1'b0;
                else begin req_a = 1'b1; addr_a = rand_addr(); data_a = 8'($urandom); end
            end else if (!req_a && $urandom_range(3, 0) == 0) begin
                req_a = 1'b1; addr_a = rand_addr(); data_a = 8'($urandom);
            end
            if (seen_b) begin
                if ($urandom_range(1, 0) == 0) req_b = 1'b0;
                else begin req_b = 1'b1; addr_b = rand_addr(); data_b = 8'($urandom); end
            end else if (!req_b && $urandom_range(3, 0) == 0) begin
                req_b = 1'b1; addr_b = rand_addr(); data_b = 8'($urandom);
            end
            seen_a = e_ga;
            seen_b = e_gb;

            pixel_tick = ~pixel_tick;
            if ($urandom_range(19, 0) == 0) video_on = ~video_on;
            pixel_x = ($urandom_range(2, 0) == 0) ? 10'($urandom_range(79, 0) * 8)
                                                  : 10'($urandom_range(639, 0));
            pixel_y = 10'($urandom_range(479, 0));

            slot = pixel_tick && video_on && ((pixel_x % 10'd8) == 10'd0);
`ifdef VRAM_BLANK_ONLY_WR_EN
            allow = !video_on;
`else
            allow = 1'b1;
`endif
            e_ga = 0; e_gb = 0; e_we = 0; e_err = 0;
            if (slot) begin
                e_kind = 1;
                e_addr = 13'((int'(pixel_y) / 8) * 80 + int'(pixel_x) / 8);
            end else if (e_kind != 2 && (req_a || req_b) && allow) begin
                pick_b = (req_a && req_b) ? !last_b : req_b;
                last_b = pick_b;
                e_kind = 2;
                e_addr = pick_b ? addr_b : addr_a;
                e_wd   = pick_b ? data_b : data_a;
                e_we   = (e_addr < 13'd4800);
                e_err  = !e_we;
                e_ga   = !pick_b;
                e_gb   = pick_b;
            end else begin
                e_kind = 0;
            end
        end
        settle();
    endtask

    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        quiet_inputs();
        test_reset();
        test_round_robin();
        test_fetch();
        test_wr_err();
        test_preempt();
        test_reset_mid();
        test_blank_gate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/vga_vram_scheduler.md
VGA_VRAM_SCHEDULER -- requirements
Module: vga_vram_scheduler

Interface
REQ-001 Port clk, input, 1: system clock; all state changes on its rising edge.
REQ-002 Port reset, input, 1: asynchronous, active-high reset.
REQ-003 Port pixel_tick, input, 1: pixel-rate enable from the sync generator, high every second clk.
REQ-004 Port video_on, input, 1: active-area flag from the sync generator.
REQ-005 Port pixel_x, input, 10: current horizontal pixel count.
REQ-006 Port pixel_y, input, 10: current vertical pixel count.
REQ-007 Ports req_a and req_b, input, 1 each: write requests from requester A and requester B.
REQ-008 Ports addr_a and addr_b, input, 13 each: tile write addresses.
REQ-009 Ports data_a and data_b, input, 8 each: tile write data.
REQ-010 Ports gnt_a and gnt_b, output, 1 each: one-cycle grant pulses.
REQ-011 Port wr_err, output, 1: one-cycle pulse marking a rejected out-of-range write.
REQ-012 Ports mem_addr (output, 13), mem_we (output, 1) and mem_wdata (output, 8): drive the single port of the synchronous tile RAM.
REQ-013 Port mem_rdata, input, 8: tile RAM read data, valid one clk after mem_addr.
REQ-014 Port tile_code, output, 8: last fetched tile code.
REQ-015 Port tile_valid, output, 1: one-cycle pulse marking new tile_code.

Function
REQ-016 Tile map: 80 columns x 60 rows of 8x8 tiles; valid addresses 0..4799.
REQ-017 disp_slot = pixel_tick & video_on & (pixel_x[2:0]==0).
REQ-018 Display fetch address = pixel_y[9:3]*80 + pixel_x[9:3]; 13-bit result, no truncation.
REQ-019 FSM states: IDLE, DISP, WR. The FSM decides each clk; mem_addr, mem_we, mem_wdata and gnt_x are registered and take their new values one cycle later.
REQ-020 disp_slot has absolute priority: next state is DISP, mem_addr gets the fetch address, mem_we is 0; this holds regardless of current state or pending requests.
REQ-021 Without disp_slot, from IDLE or DISP with any req high: next state is WR.
REQ-022 In WR: gnt of the chosen requester is 1 for exactly one cycle; mem_addr and mem_wdata hold that requester's inputs; mem_we is 1.
REQ-023 Without disp_slot, from WR: next state is IDLE, so no back-to-back write grants occur. A requester drops or renews req in the cycle after seeing gnt.
REQ-024 Round-robin arbitration:
- last_gnt register, updated on every grant.
- If both requesters request, grant the one not equal to last_gnt.
- If only one requests, grant it.
REQ-025 A write with addr >= 4800 is still granted, but mem_we stays 0 and wr_err pulses in the same cycle as gnt.
REQ-026 A DISP cycle, i.e. mem_addr carrying a fetch address in cycle N, causes:
- tile_code to load mem_rdata at the end of cycle N+1;
- tile_valid = 1 in cycle N+2 only.
REQ-027 A requester whose req is pre-empted by disp_slot is not granted; it keeps req high and is served in a later cycle.
REQ-028 mem_we = 0 in every cycle not in WR.

Reset
REQ-029 Reset forces:
- state to IDLE, last_gnt to B (A wins the first tie);
- mem_addr, mem_wdata and tile_code to 0;
- mem_we, gnt_a, gnt_b, wr_err and tile_valid to 0.
REQ-030 Reset asserted mid-write or mid-fetch aborts the operation immediately; no grant, mem_we or tile_valid pulse follows reset release for the aborted operation.

Configuration
REQ-031 Macro VRAM_BLANK_ONLY_WR_EN:
- Defined: a write grant is issued only when video_on = 0; requests during active video wait.
- Undefined: writes use any non-DISP slot, per REQ-021.

Verification
REQ-032 The bench covers these scenarios:
- Reset released, req_a = req_b = 1, video_on = 0, both held after grant: grants in order A, B, A, B on alternate cycles; mem_we pulses coincide with each grant.
- video_on = 1, pixel_x = 8, pixel_y = 16, pixel_tick = 1: mem_addr = 161 with mem_we = 0 next cycle; tile_valid pulses two cycles later with tile_code = RAM[161].
- req_a held with addr_a = 4800: gnt_a and wr_err pulse together, mem_we = 0.
- req_b rising in the same cycle as disp_slot: fetch issued first, gnt_b the cycle after.
- Reset pulsed while in WR: all outputs 0; no gnt after release unless req is still high.
- VRAM_BLANK_ONLY_WR_EN defined, req_a held during active video: no gnt_a until video_on = 0; gnt_a is first seen in the second cycle after video_on falls (decision in the first blank cycle, registered output in the next).
